icb_imu_gen2: RTL and testbench
===============================

// Module: icb_imu_gen2
// PURPOSE
//  Parametrised ICB slave sitting between the SoC ICB bus and the MHSA core (successor to the fixed 64-bit interface unit).
//  - Maps a unified SRAM of SRAM_DW-bit words onto 32-bit ICB beats, merging lane writes into byte-masked SRAM writes.
//  - Provides CSR_NUM control/status registers, including a start pulse and a sticky, W1C done flag.
//  - Uses a small FSM to keep one transaction outstanding and to honour ICB response back-pressure.
// PARAMETERS
//  SRAM_DW   64             SRAM word width; 32*2^k, k=0..3; LANES=SRAM_DW/32, LB=log2(LANES)
//  SRAM_AW   14             SRAM word-address width
//  CSR_BASE  32'h0002_0000  byte address of CSR0
//  CSR_NUM   4              number of 32-bit CSRs, >=3
// PORTS
//  clk             in   1               clock
//  rst_n           in   1               async active-low reset
//  icb_cmd_valid   in   1               command valid
//  icb_cmd_ready   out  1               command ready
//  icb_cmd_read    in   1               1=read, 0=write
//  icb_cmd_addr    in   32              byte address
//  icb_cmd_wdata   in   32              write data
//  icb_cmd_wmask   in   4               byte enables
//  icb_rsp_valid   out  1               response valid
//  icb_rsp_ready   in   1               response ready
//  icb_rsp_rdata   out  32              read data (0 for writes)
//  icb_rsp_err     out  1               response error
//  usram_addr      out  SRAM_AW         SRAM word address
//  usram_re        out  1               SRAM read strobe; data returns next cycle
//  usram_rdata     in   SRAM_DW         SRAM read data
//  usram_we        out  1               SRAM write strobe (1-cycle pulse)
//  usram_wdata     out  SRAM_DW         merged write data
//  usram_wmask     out  SRAM_DW/8       per-byte write mask
//  start_pulse     out  1               1-cycle start pulse
//  done_i          in   1               core done pulse
//  csr_q           out  CSR_NUM*32      flat CSR contents; CSR i at [32*i+:32]
// BEHAVIOUR
//  Decode:
//   - SRAM hit when addr < 2^(SRAM_AW+LB+2).
//   - Word index = addr[SRAM_AW+LB+1:LB+2]; lane = addr[LB+1:2].
//   - Lane i occupies bits [SRAM_DW-1-32*i -: 32]; lane 0 is the MSBs.
//   - CSR hit when CSR_BASE <= addr < CSR_BASE+4*CSR_NUM; any other address is unmapped.
//  FSM states IDLE, RD_WAIT, RSP:
//   - icb_cmd_ready = (state==IDLE).
//   - Accept on valid&ready. SRAM read: usram_re=1 that cycle, go to RD_WAIT, capture the lane, then RSP.
//   - All other accepts go straight to RSP.
//   - RSP: icb_rsp_valid=1, rdata and err held stable until rsp_ready; then IDLE.
//   - Minimum 2 cycles per write/CSR access and 3 per SRAM read.
//  Write merge:
//   - A lane write loads wdata into its lane of the buffer and ORs wmask into that lane's mask bits.
//   - A write to lane LANES-1 asserts usram_we for 1 cycle (cycle after accept) with that beat's word address,
//     the full buffer, and the accumulated mask; the mask then clears. Buffer data holds.
//   - LANES=1: every write flushes immediately.
//   - Reads do not disturb the buffer.
//  CSRs (byte writes honour wmask):
//   - CSR0 CTRL: writing bit0=1 fires start_pulse the cycle after accept; reads return 0.
//   - CSR1 STATUS: bit0 done is sticky, set by done_i, cleared by writing 1. Set wins over a same-cycle clear.
//   - CSR2.. : plain R/W (2=input_base, 3=output_base).
//  Unmapped access: writes are dropped; reads return 0.
//  Reset (any time, including mid-transaction): state=IDLE; ready, rsp_valid, rdata, err, usram_re, usram_we,
//  start_pulse, wdata, wmask and all CSRs = 0; any pending response is discarded.
// CONFIGURATION
//  IMU_ERR_EN defined:
//   - Unmapped accesses, and writes to read-only CSR0 bits[31:1], respond with icb_rsp_err=1.
//   - Side effects are still suppressed.
//  IMU_ERR_EN undefined: icb_rsp_err tied 0.
// TESTING
//  1. DW=64: write 0x200=A, 0x204=B -> one usram_we, addr 0x40, wdata {A,B}, wmask 8'hFF; no we after first beat.
//  2. DW=128: write lanes 3,0 only (wmask 4'hF) -> single we on lane-3 beat; wmask 16'hF00F.
//  3. SRAM read 0x204, rdata=64'h1111_2222_3333_4444 -> re at accept, rsp 2 cycles later, rdata 0x3333_4444.
//  4. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, cmd_ready=0 throughout; accept resumes after release.
//  5. done_i pulse with same-cycle W1C to CSR1 -> done stays 1; a later W1C clears it; CSR0 write 1 -> one start_pulse.
//  6. IMU_ERR_EN: read 0x3_0000 -> err=1, rdata 0. Reset asserted in RD_WAIT -> rsp_valid never rises, FSM back to IDLE.

Source files
------------

// File: rtl/icb_imu_gen2.sv
// ICB slave bridging the SoC bus to the MHSA core: lane-merging SRAM window plus CSR block.
// Optional macro IMU_ERR_EN: flag unmapped accesses and illegal CSR0 writes with icb_rsp_err.
module icb_imu_gen2 #(
    parameter int          SRAM_DW  = 64,
    parameter int          SRAM_AW  = 14,
    parameter logic [31:0] CSR_BASE = 32'h0002_0000,
    parameter int          CSR_NUM  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    icb_cmd_valid,
    output logic                    icb_cmd_ready,
    input  logic                    icb_cmd_read,
    input  logic [31:0]             icb_cmd_addr,
    input  logic [31:0]             icb_cmd_wdata,
    input  logic [3:0]              icb_cmd_wmask,
    output logic                    icb_rsp_valid,
    input  logic                    icb_rsp_ready,
    output logic [31:0]             icb_rsp_rdata,
    output logic                    icb_rsp_err,
    output logic [SRAM_AW-1:0]      usram_addr,
    output logic                    usram_re,
    input  logic [SRAM_DW-1:0]      usram_rdata,
    output logic                    usram_we,
    output logic [SRAM_DW-1:0]      usram_wdata,
    output logic [SRAM_DW/8-1:0]    usram_wmask,
    output logic                    start_pulse,
    input  logic                    done_i,
    output logic [CSR_NUM*32-1:0]   csr_q
);

    localparam int LANES  = SRAM_DW / 32;
    localparam int LB     = $clog2(LANES);
    localparam int MW     = SRAM_DW / 8;
    localparam int HIT_SH = SRAM_AW + LB + 2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
    state_t state, state_nxt;

    logic                accept, sram_hit, csr_hit, csr_sel;
    logic                sram_wr, flush, csr_wr, csr0_bad, err_nxt;
    logic                start_set, done_clr, done_flag;
    logic [31:0]         csr_off, cmd_lane, bmask, csr_rd;
    logic [29:0]         csr_idx;
    logic [SRAM_AW-1:0]  cmd_word, we_addr_p1;
    logic [31:0]         rd_lane_p1;
    logic [SRAM_DW-1:0]  wbuf_nxt;
    logic [MW-1:0]       wmacc_p0, wmacc_nxt;
    logic [31:0]         csr_regs [2:CSR_NUM-1];

    function automatic logic [31:0] lane_of(input logic [SRAM_DW-1:0] w, input logic [31:0] l);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            if (l == 32'(i)) r = w[SRAM_DW-1-32*i -: 32];
        return r;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Command decode
    assign icb_cmd_ready = (state == IDLE) && rst_n;
    assign accept        = icb_cmd_valid && icb_cmd_ready;
    assign sram_hit      = (icb_cmd_addr >> HIT_SH) == 32'd0;
    assign csr_off       = icb_cmd_addr - CSR_BASE;
    assign csr_hit       = (icb_cmd_addr >= CSR_BASE) && (csr_off < 32'(4 * CSR_NUM));
    assign csr_sel       = csr_hit && !sram_hit;
    assign csr_idx       = csr_off[31:2];
    assign cmd_lane      = (icb_cmd_addr >> 2) & 32'(LANES - 1);
    assign cmd_word      = SRAM_AW'(icb_cmd_addr >> (LB + 2));
    assign bmask         = byte_mask(icb_cmd_wmask);

`ifdef IMU_ERR_EN
    assign csr0_bad = !icb_cmd_read && csr_sel && (csr_idx == 30'd0) &&
                      (|(icb_cmd_wdata[31:1] & bmask[31:1]));
    assign err_nxt  = !(sram_hit || csr_hit) || csr0_bad;
`else
    assign csr0_bad = 1'b0;
    assign err_nxt  = 1'b0;
`endif

    assign sram_wr   = accept && !icb_cmd_read && sram_hit;
    assign flush     = sram_wr && (cmd_lane == 32'(LANES - 1));
    assign csr_wr    = accept && !icb_cmd_read && csr_sel && !csr0_bad;
    assign start_set = csr_wr && (csr_idx == 30'd0) && icb_cmd_wmask[0] && icb_cmd_wdata[0];
    assign done_clr  = csr_wr && (csr_idx == 30'd1) && icb_cmd_wmask[0] && icb_cmd_wdata[0];

    assign usram_re      = accept && icb_cmd_read && sram_hit;
    assign usram_addr    = usram_we ? we_addr_p1 : cmd_word;
    assign icb_rsp_valid = (state == RSP);

    always_comb begin
        wbuf_nxt  = usram_wdata;
        wmacc_nxt = wmacc_p0;
        for (int i = 0; i < LANES; i++) begin
            if (cmd_lane == 32'(i)) begin
                wbuf_nxt[SRAM_DW-1-32*i -: 32] = icb_cmd_wdata;
                wmacc_nxt[MW-1-4*i -: 4]       = wmacc_p0[MW-1-4*i -: 4] | icb_cmd_wmask;
            end
        end
    end

    always_comb begin
        csr_rd = '0;
        if (csr_idx == 30'd1) csr_rd = {31'b0, done_flag};
        for (int i = 2; i < CSR_NUM; i++)
            if (csr_idx == 30'(i)) csr_rd = csr_regs[i];
    end

    always_comb begin
        csr_q          = '0;
        csr_q[32 +: 32] = {31'b0, done_flag};
        for (int i = 2; i < CSR_NUM; i++)
            csr_q[32*i +: 32] = csr_regs[i];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (icb_cmd_read && sram_hit) ? RD_WAIT : RSP;
            RD_WAIT: state_nxt = RSP;
            RSP:     if (icb_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered stage: FSM, response, write buffer, CSRs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            icb_rsp_rdata <= '0;
            icb_rsp_err   <= 1'b0;
            usram_we      <= 1'b0;
            usram_wdata   <= '0;
            usram_wmask   <= '0;
            wmacc_p0      <= '0;
            we_addr_p1    <= '0;
            rd_lane_p1    <= '0;
            start_pulse   <= 1'b0;
            done_flag     <= 1'b0;
            for (int i = 2; i < CSR_NUM; i++) csr_regs[i] <= '0;
        end else begin
            state       <= state_nxt;
            usram_we    <= flush;
            start_pulse <= start_set;
            done_flag   <= done_i || (done_flag && !done_clr);
            if (sram_wr) begin
                usram_wdata <= wbuf_nxt;
                if (flush) begin
                    usram_wmask <= wmacc_nxt;
                    wmacc_p0    <= '0;
                    we_addr_p1  <= cmd_word;
                end else begin
                    wmacc_p0    <= wmacc_nxt;
                end
            end
            if (accept) begin
                icb_rsp_rdata <= (icb_cmd_read && csr_sel) ? csr_rd : 32'd0;
                icb_rsp_err   <= err_nxt;
                rd_lane_p1    <= cmd_lane;
            end
            if (state == RD_WAIT) icb_rsp_rdata <= lane_of(usram_rdata, rd_lane_p1);
            for (int i = 2; i < CSR_NUM; i++)
                if (csr_wr && csr_idx == 30'(i))
                    csr_regs[i] <= (csr_regs[i] & ~bmask) | (icb_cmd_wdata & bmask);
        end
    end

endmodule

// File: tb/tb_icb_imu_gen2.sv
// Directed bench for icb_imu_gen2: table of bus vectors plus multi-cycle corner sequences.
module tb_icb_imu_gen2;

`ifdef IMU_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic         clk = 0, rst_n = 0;
    logic         cmd_valid = 0, cmd_read = 0, rsp_ready = 1, done_i = 0;
    logic [31:0]  cmd_addr = 0, cmd_wdata = 0;
    logic [3:0]   cmd_wmask = 0;
    logic         cmd_ready, rsp_valid, rsp_err, usram_re, usram_we, start_pulse;
    logic [31:0]  rsp_rdata;
    logic [13:0]  usram_addr;
    logic [63:0]  usram_rdata, usram_wdata;
    logic [7:0]   usram_wmask;
    logic [127:0] csr_q;

    // Second instance with 128-bit SRAM words for the four-lane merge case
    logic         c2_valid = 0;
    logic [31:0]  c2_addr = 0, c2_wdata = 0;
    logic         c2_ready, c2_rsp_valid, c2_rsp_err, c2_re, c2_we, c2_start;
    logic [31:0]  c2_rdata;
    logic [13:0]  c2_uaddr;
    logic [127:0] c2_uwdata, c2_csr_q;
    logic [15:0]  c2_uwmask;

    int checks = 0, errors = 0;
    int we_cnt = 0, re_cnt = 0, st_cnt = 0, we2_cnt = 0;
    logic [13:0]  we_addr, re_addr, we2_addr;
    logic [63:0]  we_data;
    logic [7:0]   we_mask;
    logic [127:0] we2_data;
    logic [15:0]  we2_mask;

    icb_imu_gen2 u_dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_read(cmd_read),
        .icb_cmd_addr(cmd_addr), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
        .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
        .icb_rsp_err(rsp_err), .usram_addr(usram_addr), .usram_re(usram_re),
        .usram_rdata(usram_rdata), .usram_we(usram_we), .usram_wdata(usram_wdata),
        .usram_wmask(usram_wmask), .start_pulse(start_pulse), .done_i(done_i), .csr_q(csr_q)
    );

    icb_imu_gen2 #(.SRAM_DW(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(c2_valid), .icb_cmd_ready(c2_ready), .icb_cmd_read(1'b0),
        .icb_cmd_addr(c2_addr), .icb_cmd_wdata(c2_wdata), .icb_cmd_wmask(4'hF),
        .icb_rsp_valid(c2_rsp_valid), .icb_rsp_ready(1'b1), .icb_rsp_rdata(c2_rdata),
        .icb_rsp_err(c2_rsp_err), .usram_addr(c2_uaddr), .usram_re(c2_re),
        .usram_rdata(128'd0), .usram_we(c2_we), .usram_wdata(c2_uwdata),
        .usram_wmask(c2_uwmask), .start_pulse(c2_start), .done_i(1'b0), .csr_q(c2_csr_q)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, fixed pattern per word
    always @(posedge clk)
        if (usram_re)
            usram_rdata <= (usram_addr == 14'h40) ? 64'h1111_2222_3333_4444
                         : {16'hC0DE, 2'b00, usram_addr, 16'hBEEF, 2'b00, usram_addr};

    always @(negedge clk) begin
        if (usram_we) begin we_cnt++; we_addr = usram_addr; we_data = usram_wdata; we_mask = usram_wmask; end
        if (usram_re) begin re_cnt++; re_addr = usram_addr; end
        if (start_pulse) st_cnt++;
        if (c2_we) begin we2_cnt++; we2_addr = c2_uaddr; we2_data = c2_uwdata; we2_mask = c2_uwmask; end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, output logic [31:0] rdat, output logic er,
                        output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1 cmd_valid = 0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        rdat = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic xfer128(input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        c2_valid = 1; c2_addr = a; c2_wdata = wd;
        n = 0;
        while (!c2_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 c2_valid = 0;
        n = 0;
        @(negedge clk);
        while (!c2_rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!c2_rsp_valid) chk("rsp128_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, base, n;
        logic        stable;

        vecs[0]  = '{0, 32'h0002_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1, 32'h0002_0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 32'h0002_000C, 32'h1234_5678, 4'h5, 32'h0,         1'b0};
        vecs[3]  = '{1, 32'h0002_000C, 32'h0,         4'h0, 32'h0034_0078, 1'b0};
        vecs[4]  = '{1, 32'h0002_0000, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[5]  = '{1, 32'h0002_0004, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[6]  = '{1, 32'h0000_0200, 32'h0,         4'h0, 32'h1111_2222, 1'b0};
        vecs[7]  = '{1, 32'h0000_0010, 32'h0,         4'h0, 32'hC0DE_0002, 1'b0};
        vecs[8]  = '{1, 32'h0000_001C, 32'h0,         4'h0, 32'hBEEF_0003, 1'b0};
        vecs[9]  = '{1, 32'h0001_FFFC, 32'h0,         4'h0, 32'hBEEF_3FFF, 1'b0};
        vecs[10] = '{1, 32'h0003_0000, 32'h0,         4'h0, 32'h0,         ERR};
        vecs[11] = '{1, 32'h0002_0010, 32'h0,         4'h0, 32'h0,         ERR};
        vecs[12] = '{0, 32'h0003_0000, 32'h5555_5555, 4'hF, 32'h0,         ERR};
        vecs[13] = '{0, 32'h0002_0000, 32'h0000_0002, 4'hF, 32'h0,         ERR};
        vecs[14] = '{1, 32'h0002_0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready_after", cmd_ready, 1);
        chk("rst_outputs", {rsp_rdata, rsp_err, usram_we, start_pulse, usram_wmask}, 0);
        chk("rst_wdata", usram_wdata, 0);
        chk("rst_csr_q", csr_q, 0);

        // Table-driven bus vectors
        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        end
        chk("csr_q_23", csr_q[127:64], {32'h0034_0078, 32'hDEAD_BEEF});
        chk("no_start_from_table", st_cnt, 0);
        chk("no_we_from_table", we_cnt, 0);

        // SRAM read latency and lane select
        base = re_cnt;
        xfer(1, 32'h204, 0, 0, rd, er, lat);
        chk("rd204_rdata", rd, 32'h3333_4444);
        chk("rd204_latency", lat, 2);
        chk("rd204_re_cnt", re_cnt - base, 1);
        chk("rd204_re_addr", re_addr, 14'h40);
        xfer(0, 32'h2_0008, 0, 0, rd, er, lat);
        chk("csr_wr_latency", lat, 1);

        // Two-lane merge, with an interleaved read that must not disturb the buffer
        base = we_cnt;
        xfer(0, 32'h200, 32'hAAAA_0001, 4'hF, rd, er, lat);
        chk("merge_no_we_first", we_cnt - base, 0);
        xfer(1, 32'h10, 0, 0, rd, er, lat);
        xfer(0, 32'h204, 32'hBBBB_0002, 4'hF, rd, er, lat);
        chk("merge_we_cnt", we_cnt - base, 1);
        chk("merge_addr", we_addr, 14'h40);
        chk("merge_wdata", we_data, 64'hAAAA_0001_BBBB_0002);
        chk("merge_wmask", we_mask, 8'hFF);
        xfer(0, 32'h208, 32'hCCCC_0003, 4'h3, rd, er, lat);
        xfer(0, 32'h20C, 32'hDDDD_0004, 4'h0, rd, er, lat);
        chk("merge2_we_cnt", we_cnt - base, 2);
        chk("merge2_addr", we_addr, 14'h41);
        chk("merge2_wdata", we_data, 64'hCCCC_0003_DDDD_0004);
        chk("merge2_wmask", we_mask, 8'h30);

        // Four-lane instance: lanes 0 and 3 only
        xfer128(32'h100, 32'hD000_0000);
        chk("w128_no_we_first", we2_cnt, 0);
        xfer128(32'h10C, 32'h0000_000D);
        chk("w128_we_cnt", we2_cnt, 1);
        chk("w128_addr", we2_addr, 14'h10);
        chk("w128_wdata", we2_data, {32'hD000_0000, 64'd0, 32'h0000_000D});
        chk("w128_wmask", we2_mask, 16'hF00F);

        // Response back-pressure with a second command pending
        rsp_ready = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_read = 1; cmd_addr = 32'h2_0008;
        @(posedge clk); #1 cmd_addr = 32'h2_000C;
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            stable = stable && rsp_valid && (rsp_rdata == 32'hDEAD_BEEF) && !cmd_ready;
        end
        chk("bp_stable", stable, 1);
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_release", {cmd_ready, rsp_valid}, 2'b10);
        @(posedge clk); #1 cmd_valid = 0;
        @(negedge clk);
        chk("bp_next_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'h0034_0078});
        @(posedge clk); #1;

        // done_i pulse coinciding with a W1C to STATUS: set wins
        @(negedge clk);
        cmd_valid = 1; cmd_read = 0; cmd_addr = 32'h2_0004; cmd_wdata = 1; cmd_wmask = 4'h1;
        done_i = 1;
        @(posedge clk); #1 cmd_valid = 0; done_i = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        chk("done_set_wins", csr_q[32], 1);
        xfer(1, 32'h2_0004, 0, 0, rd, er, lat);
        chk("done_read", rd, 1);
        xfer(0, 32'h2_0004, 1, 4'h1, rd, er, lat);
        chk("done_w1c", csr_q[32], 0);

        // Start pulse
        xfer(0, 32'h2_0000, 1, 4'hE, rd, er, lat);
        chk("start_masked", st_cnt, 0);
        xfer(0, 32'h2_0000, 1, 4'hF, rd, er, lat);
        chk("start_once", st_cnt, 1);

        // Reset asserted while waiting on SRAM read data
        @(negedge clk);
        cmd_valid = 1; cmd_read = 1; cmd_addr = 32'h204;
        @(posedge clk); #1 cmd_valid = 0; rst_n = 0;
        stable = 1;
        repeat (3) begin
            @(negedge clk);
            stable = stable && !rsp_valid && !cmd_ready && !usram_we && !start_pulse;
        end
        chk("rst_mid_quiet", stable, 1);
        chk("rst_mid_csr", csr_q, 0);
        chk("rst_mid_rsp", {rsp_rdata, rsp_err, usram_wdata, usram_wmask}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_mid_idle", {cmd_ready, rsp_valid}, 2'b10);
        xfer(1, 32'h2_0008, 0, 0, rd, er, lat);
        chk("rst_mid_csr2_cleared", rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
